y_generate: RTL
===============

// Module: y_generate
// PURPOSE
//  Transmit-side channel model; the inverse of x_calculate. Takes a 4x4 complex channel H (Q8.8)
//  and 16 QPSK bits (4 tx antennas x 2 slots), computes Y = H*x (4 rx x 2 slots) and streams the
//  8 Y samples out on the same valid/r/i protocol x_calculate consumes. Used to self-check detector chain.
// PARAMETERS
//  Q          8      fractional bits of all fixed-point samples
//  N          16     sample width (signed, real and imag each)
//  ACC_WIDTH  32     internal accumulator/product width
//  QPSK_AMP   181    QPSK per-axis amplitude, Q8.8 (~0.7071)
//  NOISE_SH   10     noise scale: noise = lfsr[N-1:0] >>> NOISE_SH (only with Y_NOISE_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start_new_q  in   1   start pulse; latches bits_in
//  bits_in      in   16  QPSK bits; slot t, antenna k: bit 2(4t+k)=I sign, bit 2(4t+k)+1=Q sign; 0->+A, 1->-A
//  H_in_valid   in   1   H beat valid
//  H_in_r       in   N   H real, row-major H[r][c], r,c=0..3
//  H_in_i       in   N   H imag
//  Y_out_valid  out  1   Y beat valid
//  Y_out_r      out  N   Y real; order slot0 rx0..3, then slot1 rx0..3
//  Y_out_i      out  N   Y imag
//  busy         out  1   high in any state except IDLE
//  done         out  1   one-cycle pulse, cycle after last Y beat
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, state IDLE, H/Y buffers and counters cleared; mid-operation reset aborts.
//  FSM IDLE -> LOAD_H -> COMPUTE -> STREAM -> IDLE.
//  IDLE: start_new_q=1 latches bits_in, -> LOAD_H. start_new_q in any other state ignored.
//  LOAD_H: each cycle with H_in_valid=1 stores one beat; gaps allowed; 16th beat -> COMPUTE.
//   H_in_valid outside LOAD_H ignored.
//  COMPUTE: per Y[r][t] (t outer, r inner): 4 cycles sign-accumulate k=0..3, 1 cycle scale/store; 40 cycles total.
//   sr,si = +/-1 from bits of x[k][t]. accR += sr*Hr[r][k] - si*Hi[r][k]; accI += si*Hr[r][k] + sr*Hi[r][k].
//   Accumulators N+3 bits signed; scale: (acc*QPSK_AMP) >>> Q (arithmetic, truncate), saturate to N-bit range.
//  STREAM: entered on the 41st edge after the 16th H beat; Y_out_valid high 8 consecutive cycles,
//   no backpressure; Y_out_r/i hold 0 when valid low. done pulses next cycle; busy drops with done.
// CONFIGURATION
//  Y_NOISE_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances
//   once per scale cycle; (lfsr >>> NOISE_SH) added to real, bit-reversed lfsr >>> NOISE_SH to imag,
//   before saturation.
//  Y_NOISE_EN undefined: no LFSR logic; output exactly the noiseless saturated result.
// STRUCTURE
//  mimo_pkg: Q/N defaults, QPSK_AMP, state enum (IDLE,LOAD_H,COMPUTE,STREAM), cplx_t struct {r,i}, sat_n function.
//  Sub-module qpsk_sign_mac: one complex +/- accumulate lane plus scale/saturate; y_generate holds FSM, buffers, counters.
// TESTING
//  1 H=I*256 (1.0+j0), bits=0 -> all 8 Y = 181+j181; done one cycle after 8th beat.
//  2 H=I*256, bits=16'h0003 -> Y[0][0]=-181-j181, other 7 = 181+j181.
//  3 H all 0x7FFF+j0, bits=0 -> all Y = 32767+j32767 (saturation); bits=16'hFFFF -> -32768-j32768.
//  4 16 H beats with H_in_valid gaps every other cycle -> same Y as test 1; first Y_out_valid on
//    41st edge after 16th beat.
//  5 start_new_q pulsed during COMPUTE, H_in_valid in STREAM -> ignored, Y unchanged.
//  6 rst_n low mid-COMPUTE -> outputs 0 immediately, busy=0; new full transaction after release passes test 1.

Source files
------------

// File: rtl/mimo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mimo_pkg                                                         |
// | Purpose : Shared constants, FSM state type, complex sample type and the    |
// |           N-bit saturation helper for the y_generate channel model.        |
// | Ports   : none (package)                                                   |
// | Config  : Y_NOISE_EN is consumed by qpsk_sign_mac, not by this package.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mimo_pkg;

  localparam int Q         = 8;      // fractional bits of all samples
  localparam int N         = 16;     // sample width (real and imag each)
  localparam int ACC_WIDTH = 32;     // product / scaled-sum width
  localparam int QPSK_AMP  = 181;    // ~0.7071 in Q8.8
  localparam int NOISE_SH  = 10;     // noise attenuation shift
  localparam int ACC_N     = N + 3;  // sum of four +/-(Hr +/- Hi) terms needs 3 guard bits

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_H  = 2'd1,
    COMPUTE = 2'd2,
    STREAM  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [N-1:0] r;
    logic signed [N-1:0] i;
  } cplx_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (N - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -SAT_HI - 1;

  // Clamp a wide signed value into the signed N-bit range.
  function automatic logic signed [N-1:0] sat_n(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [N-1:0] res;
    if (v > SAT_HI) begin
      res = SAT_HI[N-1:0];
    end else if (v < SAT_LO) begin
      res = SAT_LO[N-1:0];
    end else begin
      res = v[N-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/y_generate_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : y_generate_if                                                  |
// | Purpose   : One complex sample stream beat (valid + real + imag).          |
// | Signals   : valid - beat valid                                             |
// |             r, i  - signed N-bit real / imaginary parts                    |
// | Modports  : master drives the beat, slave receives it.                     |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface y_generate_if #(
  parameter int N = 16
);
  logic                valid;
  logic signed [N-1:0] r;
  logic signed [N-1:0] i;

  modport master (output valid, output r, output i);
  modport slave  (input  valid, input  r, input  i);
endinterface
`default_nettype wire

// File: rtl/y_generate_qpsk_sign_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : qpsk_sign_mac                                                    |
// | Purpose : One complex lane: accumulates (sr + j*si) * H over four taps,    |
// |           then scales by QPSK_AMP, shifts by Q and saturates to N bits.    |
// | Ports   : clk, rst_n       - clock, async active-low reset                 |
// |           acc_en, first    - accumulate this cycle / restart the sum       |
// |           scale_en         - scale cycle (only with Y_NOISE_EN)            |
// |           sr_neg, si_neg   - QPSK sign bits of x (1 -> -A)                 |
// |           h                - channel tap                                   |
// |           y                - scaled, saturated result (combinational)      |
// | Config  : Y_NOISE_EN adds LFSR noise before saturation.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module qpsk_sign_mac
  import mimo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  acc_en,
  input  logic  first,
`ifdef Y_NOISE_EN
  input  logic  scale_en,
`endif
  input  logic  sr_neg,
  input  logic  si_neg,
  input  cplx_t h,
  output cplx_t y
);

  localparam logic signed [ACC_WIDTH-1:0] AMP = ACC_WIDTH'(QPSK_AMP);

  logic signed [ACC_N-1:0]     acc_r, acc_i, hr, hi, term_r, term_i;
  logic signed [ACC_WIDTH-1:0] prod_r, prod_i, noise_r, noise_i;

  assign hr = $signed({{(ACC_N - N){h.r[N-1]}}, h.r});
  assign hi = $signed({{(ACC_N - N){h.i[N-1]}}, h.i});

  // (sr + j si)(Hr + j Hi) with sr, si in {+1, -1}: only sign flips, no multiplier.
  always_comb begin
    term_r = (sr_neg ? -hr : hr) + (si_neg ? hi : -hi);
    term_i = (si_neg ? -hr : hr) + (sr_neg ? -hi : hi);
  end

  // The k=0 tap overwrites the sum, so no separate clear cycle is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      acc_i <= '0;
    end else if (acc_en) begin
      acc_r <= first ? term_r : acc_r + term_r;
      acc_i <= first ? term_i : acc_i + term_i;
    end
  end

`ifdef Y_NOISE_EN
  logic [15:0]                 lfsr, lfsr_rev;
  logic signed [ACC_WIDTH-1:0] lfsr_ext, lfsr_rev_ext;

  // Fibonacci LFSR, taps 16,14,13,11; steps once per produced sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (scale_en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  for (genvar b = 0; b < 16; b++) begin : g_rev
    assign lfsr_rev[b] = lfsr[15-b];
  end

  assign lfsr_ext     = $signed({{(ACC_WIDTH - 16){lfsr[15]}}, lfsr});
  assign lfsr_rev_ext = $signed({{(ACC_WIDTH - 16){lfsr_rev[15]}}, lfsr_rev});
  assign noise_r      = lfsr_ext >>> NOISE_SH;
  assign noise_i      = lfsr_rev_ext >>> NOISE_SH;
`else
  assign noise_r = '0;
  assign noise_i = '0;
`endif

  assign prod_r = $signed({{(ACC_WIDTH - ACC_N){acc_r[ACC_N-1]}}, acc_r}) * AMP;
  assign prod_i = $signed({{(ACC_WIDTH - ACC_N){acc_i[ACC_N-1]}}, acc_i}) * AMP;

  always_comb begin
    y.r = sat_n((prod_r >>> Q) + noise_r);
    y.i = sat_n((prod_i >>> Q) + noise_i);
  end

endmodule
`default_nettype wire

// File: rtl/y_generate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : y_generate                                                       |
// | Purpose : Transmit-side channel model Y = H*x for a 4x4 MIMO link with     |
// |           QPSK symbols over 2 slots; streams 8 Y samples.                  |
// | Ports   : clk, rst_n   - clock, async active-low reset                     |
// |           start_new_q  - start pulse, latches bits_in (IDLE only)          |
// |           bits_in      - 16 QPSK sign bits                                 |
// |           h_in         - H beats, row-major H[r][c] (slave)                |
// |           y_out        - Y beats, slot0 rx0..3 then slot1 (master)         |
// |           busy         - high outside IDLE                                 |
// |           done         - one-cycle pulse after the last Y beat             |
// | Config  : Y_NOISE_EN enables LFSR noise in the MAC lane.                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module y_generate
  import mimo_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_new_q,
  input  logic [15:0]  bits_in,
  y_generate_if.slave  h_in,
  y_generate_if.master y_out,
  output logic         busy,
  output logic         done
);

  state_t      state_q, state_d;
  logic [15:0] bits_q;
  cplx_t       h_buf [16];
  cplx_t       y_buf [8];
  logic [3:0]  h_cnt;
  logic [2:0]  k_cnt;     // 0..3 accumulate tap k, 4 = scale/store
  logic [2:0]  y_idx;     // {t, r}: slot outer, rx inner
  logic [2:0]  out_cnt;
  logic        done_q;

  logic        in_compute, scale_cyc;
  logic [3:0]  h_idx;
  logic [2:0]  x_idx;
  cplx_t       mac_y;

  assign in_compute = (state_q == COMPUTE);
  assign scale_cyc  = in_compute && (k_cnt == 3'd4);
  assign h_idx      = {y_idx[1:0], k_cnt[1:0]};   // H[r][k]
  assign x_idx      = {y_idx[2], k_cnt[1:0]};     // x[k][t] -> bit pair 4t+k

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_new_q) state_d = LOAD_H;
      LOAD_H:  if (h_in.valid && h_cnt == 4'd15) state_d = COMPUTE;
      COMPUTE: if (scale_cyc && y_idx == 3'd7) state_d = STREAM;
      STREAM:  if (out_cnt == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters wrap to zero at the end of their phase, so each phase starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bits_q  <= '0;
      h_cnt   <= '0;
      k_cnt   <= '0;
      y_idx   <= '0;
      out_cnt <= '0;
      done_q  <= 1'b0;
      for (int j = 0; j < 16; j++) h_buf[j] <= '0;
      for (int j = 0; j < 8; j++)  y_buf[j] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == STREAM) && (out_cnt == 3'd7);
      case (state_q)
        IDLE: if (start_new_q) bits_q <= bits_in;
        LOAD_H: if (h_in.valid) begin
          h_buf[h_cnt] <= '{r: h_in.r, i: h_in.i};
          h_cnt        <= h_cnt + 4'd1;
        end
        COMPUTE: if (scale_cyc) begin
          y_buf[y_idx] <= mac_y;
          y_idx        <= y_idx + 3'd1;
          k_cnt        <= '0;
        end else begin
          k_cnt <= k_cnt + 3'd1;
        end
        STREAM: out_cnt <= out_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  qpsk_sign_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_en   (in_compute && !scale_cyc),
    .first    (k_cnt == 3'd0),
`ifdef Y_NOISE_EN
    .scale_en (scale_cyc),
`endif
    .sr_neg   (bits_q[{x_idx, 1'b0}]),
    .si_neg   (bits_q[{x_idx, 1'b1}]),
    .h        (h_buf[h_idx]),
    .y        (mac_y)
  );

  assign y_out.valid = (state_q == STREAM);
  assign y_out.r     = y_out.valid ? y_buf[out_cnt].r : '0;
  assign y_out.i     = y_out.valid ? y_buf[out_cnt].i : '0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule
`default_nettype wire
